// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - ID/EX inputs and EX/MEM outputs of the execute stage.
interface ex_stage_if;
  logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
  logic [2:0]  ALUControlE;
  logic [31:0] srcaE, srcbE, SignImmE;
  logic [4:0]  RtE, RdE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW;
  logic        StallE;
  logic        RegWriteM, MemtoRegM, MemWriteM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [4:0]  WriteRegM;
  logic        ZeroM;

  modport master (
    output RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
           srcaE, srcbE, SignImmE, RtE, RdE, ForwardAE, ForwardBE, ResultW,
    input  StallE, RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM,
           WriteRegM, ZeroM
  );

  modport slave (
    input  RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
           srcaE, srcbE, SignImmE, RtE, RdE, ForwardAE, ForwardBE, ResultW,
    output StallE, RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM,
           WriteRegM, ZeroM
  );
endinterface

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: forwarding, ALU, EX/MEM register, optional
// 32-cycle shift-add multiplier enabled by macro EX_STAGE_MUL_EN.
module ex_stage (
  input  logic     clk,
  input  logic     rstn,
  input  logic     clr,
  ex_stage_if.slave ex
);
  logic [31:0] opa, wdata, opb, alu_res, acc_val;
  logic [4:0]  wreg;
  logic        stall, load_acc;

  logic        rw_q, rw_d, mtr_q, mtr_d, mw_q, mw_d, zero_q, zero_d;
  logic [31:0] alu_q, alu_d, wd_q, wd_d, result_sel;
  logic [4:0]  wr_q, wr_d;

  always_comb begin
    case (ex.ForwardAE)
      2'b01:   opa = ex.ResultW;
      2'b10:   opa = alu_q;
      default: opa = ex.srcaE;
    endcase
    case (ex.ForwardBE)
      2'b01:   wdata = ex.ResultW;
      2'b10:   wdata = alu_q;
      default: wdata = ex.srcbE;
    endcase
  end

  assign opb  = ex.ALUSrcE ? ex.SignImmE : wdata;
  assign wreg = ex.RegDstE ? ex.RdE : ex.RtE;

  // Op 011 yields 0 here; a real product only arrives via the accumulator path.
  always_comb begin
    alu_res = '0;
    case (ex.ALUControlE)
      3'b010:  alu_res = opa + opb;
      3'b110:  alu_res = opa - opb;
      3'b000:  alu_res = opa & opb;
      3'b001:  alu_res = opa | opb;
      3'b111:  alu_res = {31'd0, ($signed(opa) < $signed(opb))};
      default: alu_res = '0;
    endcase
  end

`ifdef EX_STAGE_MUL_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;
  mul_state_t  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    stall    = 1'b0;
    load_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex.ALUControlE == 3'b011) begin
          stall = 1'b1;
          if (!clr) begin
            mcand_d  = opa;
            mplier_d = opb;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = BUSY;
          end
        end
      end
      BUSY: begin
        stall    = 1'b1;
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = DONE;
      end
      DONE: begin
        load_acc = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign acc_val = acc_q;
`else
  assign stall    = 1'b0;
  assign load_acc = 1'b0;
  assign acc_val  = '0;
`endif

  assign result_sel = load_acc ? acc_val : alu_res;

  // Flush and stall both load an all-zero bubble into EX/MEM.
  always_comb begin
    rw_d   = 1'b0;
    mtr_d  = 1'b0;
    mw_d   = 1'b0;
    alu_d  = '0;
    wd_d   = '0;
    wr_d   = '0;
    zero_d = 1'b0;
    if (!clr && !stall) begin
      rw_d   = ex.RegWriteE;
      mtr_d  = ex.MemtoRegE;
      mw_d   = ex.MemWriteE;
      alu_d  = result_sel;
      wd_d   = wdata;
      wr_d   = wreg;
      zero_d = (result_sel == 32'd0);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rw_q   <= 1'b0;
      mtr_q  <= 1'b0;
      mw_q   <= 1'b0;
      alu_q  <= '0;
      wd_q   <= '0;
      wr_q   <= '0;
      zero_q <= 1'b0;
    end else begin
      rw_q   <= rw_d;
      mtr_q  <= mtr_d;
      mw_q   <= mw_d;
      alu_q  <= alu_d;
      wd_q   <= wd_d;
      wr_q   <= wr_d;
      zero_q <= zero_d;
    end
  end

  assign ex.StallE     = stall;
  assign ex.RegWriteM  = rw_q;
  assign ex.MemtoRegM  = mtr_q;
  assign ex.MemWriteM  = mw_q;
  assign ex.ALUOutM    = alu_q;
  assign ex.WriteDataM = wd_q;
  assign ex.WriteRegM  = wr_q;
  assign ex.ZeroM      = zero_q;
endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - randomized bench for ex_stage against a cycle-count model.
module tb_ex_stage;
`ifdef EX_STAGE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn, clr;
  always #5 clk = ~clk;

  ex_stage_if bus ();
  ex_stage dut (.clk(clk), .rstn(rstn), .clr(clr), .ex(bus));

  int n_cmp = 0;
  int n_bad = 0;

  logic        exp_rw, exp_mtr, exp_mw, exp_zero, exp_stall, last_stall;
  logic [31:0] exp_alu, exp_wd;
  logic [4:0]  exp_wr;
  logic        nx_rw, nx_mtr, nx_mw, nx_zero;
  logic [31:0] nx_alu, nx_wd;
  logic [4:0]  nx_wr;
  // Multiply in flight: m_cyc counts cycles since the op entered EX.
  bit          m_active, nx_m_active;
  int          m_cyc, nx_m_cyc;
  logic [31:0] m_a, m_b, nx_m_a, nx_m_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] r);
    if (s == 2'b01) return bus.ResultW;
    if (s == 2'b10) return exp_alu;
    return r;
  endfunction

  task automatic model_reset();
    {exp_rw, exp_mtr, exp_mw, exp_zero} = '0;
    exp_alu = '0; exp_wd = '0; exp_wr = '0;
    m_active = 0; m_cyc = 0; m_a = '0; m_b = '0;
  endtask

  task automatic model_eval();
    logic [31:0] a, wd, b, r;
    a  = pick(bus.ForwardAE, bus.srcaE);
    wd = pick(bus.ForwardBE, bus.srcbE);
    b  = bus.ALUSrcE ? bus.SignImmE : wd;
    case (bus.ALUControlE)
      3'b010:  r = a + b;
      3'b110:  r = a - b;
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b111:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    exp_stall = MUL_EN && ((!m_active && bus.ALUControlE == 3'b011) ||
                           (m_active && m_cyc <= 32));
    {nx_rw, nx_mtr, nx_mw, nx_zero} = '0;
    nx_alu = '0; nx_wd = '0; nx_wr = '0;
    nx_m_active = m_active; nx_m_cyc = m_cyc; nx_m_a = m_a; nx_m_b = m_b;
    if (clr) begin
      nx_m_active = 0;
    end else if (exp_stall) begin
      if (!m_active) begin
        nx_m_active = 1; nx_m_cyc = 1; nx_m_a = a; nx_m_b = b;
      end else begin
        nx_m_cyc = m_cyc + 1;
      end
    end else begin
      nx_rw  = bus.RegWriteE;
      nx_mtr = bus.MemtoRegE;
      nx_mw  = bus.MemWriteE;
      nx_alu = m_active ? m_a * m_b : r;
      nx_wd  = wd;
      nx_wr  = bus.RegDstE ? bus.RdE : bus.RtE;
      nx_zero = (nx_alu == 32'd0);
      nx_m_active = 0;
    end
  endtask

  task automatic check_m();
    check("RegWriteM",  bus.RegWriteM,  exp_rw);
    check("MemtoRegM",  bus.MemtoRegM,  exp_mtr);
    check("MemWriteM",  bus.MemWriteM,  exp_mw);
    check("ALUOutM",    bus.ALUOutM,    exp_alu);
    check("WriteDataM", bus.WriteDataM, exp_wd);
    check("WriteRegM",  bus.WriteRegM,  exp_wr);
    check("ZeroM",      bus.ZeroM,      exp_zero);
  endtask

  // Called right at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    #1;
    model_eval();
    last_stall = bus.StallE;
    check("StallE", bus.StallE, exp_stall);
    @(posedge clk);
    exp_rw = nx_rw; exp_mtr = nx_mtr; exp_mw = nx_mw; exp_alu = nx_alu;
    exp_wd = nx_wd; exp_wr = nx_wr; exp_zero = nx_zero;
    m_active = nx_m_active; m_cyc = nx_m_cyc; m_a = nx_m_a; m_b = nx_m_b;
    #1;
    check_m();
    @(negedge clk);
  endtask

  task automatic zero_inputs();
    {bus.RegWriteE, bus.MemtoRegE, bus.MemWriteE, bus.ALUSrcE, bus.RegDstE} = '0;
    bus.ALUControlE = 3'b000;
    bus.srcaE = '0; bus.srcbE = '0; bus.SignImmE = '0;
    bus.RtE = '0; bus.RdE = '0;
    bus.ForwardAE = 2'b00; bus.ForwardBE = 2'b00;
    bus.ResultW = '0;
  endtask

  task automatic set_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.ALUControlE = op; bus.srcaE = a; bus.srcbE = b;
    bus.ALUSrcE = 1'b0; bus.ForwardAE = 2'b00; bus.ForwardBE = 2'b00;
    bus.RegWriteE = 1'b1;
  endtask

  task automatic randomize_inputs();
    logic [2:0] op;
    op = 3'($urandom_range(0, 7));
    if (op == 3'b011 && $urandom_range(0, 5) != 0) op = 3'b010;
    bus.ALUControlE = op;
    bus.srcaE    = $urandom();
    bus.srcbE    = ($urandom_range(0, 4) == 0) ? bus.srcaE : $urandom();
    bus.SignImmE = 32'($signed(16'($urandom())));
    bus.ResultW  = $urandom();
    bus.ForwardAE = 2'($urandom_range(0, 3));
    bus.ForwardBE = 2'($urandom_range(0, 3));
    {bus.RegWriteE, bus.MemtoRegE, bus.MemWriteE, bus.ALUSrcE, bus.RegDstE} = 5'($urandom());
    bus.RtE = 5'($urandom()); bus.RdE = 5'($urandom());
    clr = ($urandom_range(0, 24) == 0);
  endtask

`ifdef EX_STAGE_MUL_EN
  // Runs until StallE is seen low; returns the number of stalled cycles.
  task automatic run_mul(output int stalls, input bit poke_fwd);
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (!last_stall) break;
      stalls++;
      if (poke_fwd && i > 2) begin
        bus.ForwardAE = 2'b01;
        bus.ResultW = $urandom();
      end
    end
  endtask
`endif

  initial begin
    rstn = 1'b0; clr = 1'b0;
    zero_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset ALUOutM", bus.ALUOutM, 32'd0);
    check("reset RegWriteM", bus.RegWriteM, 32'd0);
    check("reset ZeroM", bus.ZeroM, 32'd0);
    check("reset StallE", bus.StallE, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    set_op(3'b010, 32'd5, 32'd7);
    bus.RtE = 5'd3; bus.RdE = 5'd8; bus.RegDstE = 1'b1;
    cycle();
    check("add ALUOutM", bus.ALUOutM, 32'd12);
    check("add ZeroM", bus.ZeroM, 32'd0);
    check("add WriteRegM", bus.WriteRegM, 32'd8);

    set_op(3'b010, 32'd4, 32'd5);
    cycle();
    set_op(3'b110, 32'd1234, 32'd9);
    bus.ForwardAE = 2'b10;
    cycle();
    check("sub fwd ALUOutM", bus.ALUOutM, 32'd0);
    check("sub fwd ZeroM", bus.ZeroM, 32'd1);

    set_op(3'b111, 32'hFFFF_FFFF, 32'd1);
    cycle();
    check("slt ALUOutM", bus.ALUOutM, 32'd1);

    set_op(3'b001, 32'h0000_00F0, 32'd0);
    bus.ALUSrcE = 1'b1; bus.SignImmE = 32'hFFFF_FF0F;
    cycle();
    check("or imm ALUOutM", bus.ALUOutM, 32'hFFFF_FFFF);

    set_op(3'b011, 32'd9, 32'd9);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    check("clr+mul ALUOutM", bus.ALUOutM, 32'd0);
    set_op(3'b010, 32'd1, 32'd1);
    cycle();
    check("after clr+mul StallE", last_stall, 32'd0);
    check("after clr+mul ALUOutM", bus.ALUOutM, 32'd2);

`ifdef EX_STAGE_MUL_EN
    begin
      int stalls;
      set_op(3'b011, 32'hFFFF_FFFF, 32'd3);
      run_mul(stalls, 1'b1);
      check("mul stall cycles", stalls, 32'd33);
      check("mul product", bus.ALUOutM, 32'hFFFF_FFFD);

      set_op(3'b011, 32'd7, 32'd6);
      repeat (11) cycle();
      rstn = 1'b0;
      zero_inputs();
      #1;
      model_reset();
      check("async rst ALUOutM", bus.ALUOutM, 32'd0);
      check("async rst RegWriteM", bus.RegWriteM, 32'd0);
      check("async rst StallE", bus.StallE, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      set_op(3'b011, 32'd7, 32'd6);
      run_mul(stalls, 1'b0);
      check("reissue stall cycles", stalls, 32'd33);
      check("reissue product", bus.ALUOutM, 32'd42);

      set_op(3'b011, 32'd5, 32'd5);
      repeat (6) cycle();
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      check("clr busy ALUOutM", bus.ALUOutM, 32'd0);
      check("clr busy RegWriteM", bus.RegWriteM, 32'd0);
      set_op(3'b001, 32'd0, 32'd0);
      cycle();
      check("after clr StallE", last_stall, 32'd0);
      check("after clr no product", bus.ALUOutM, 32'd0);
    end
`else
    set_op(3'b011, 32'd4, 32'd4);
    cycle();
    check("mul off StallE", last_stall, 32'd0);
    check("mul off ALUOutM", bus.ALUOutM, 32'd0);
    check("mul off ZeroM", bus.ZeroM, 32'd1);
`endif

    repeat (500) begin
      randomize_inputs();
      cycle();
    end
    clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
